// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_pkg
// Description : Shared state encoding and byte width for the UART TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int UTXA_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOCK   = 3'd1,
        FIRE   = 3'd2,
        SETTLE = 3'd3,
        DRAIN  = 3'd4
    } utxa_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick; search starts one past i_ptr.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx
);

    logic w_found;
    int   w_j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 1; k <= N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IW'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, message-locked sharing of one uart_tx among
//               N_REQ ready/valid byte streams.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int N_REQ          = 4,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int GRANT_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [UTXA_BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]             req_last,
    output logic [N_REQ-1:0]             req_ready,
    output logic [UTXA_BYTE_W-1:0]       utx_data,
    output logic                         utx_valid,
    input  logic                         utx_busy,
    output logic [GRANT_W-1:0]           grant_id,
    output logic                         grant_active,
    output logic                         timeout_evt
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last =
        c_cnt_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [c_cnt_w-1:0] c_cnt_max = '1;
    localparam bit c_to_en = (TIMEOUT_CYCLES != 0);

    utxa_state_t             r_state, w_state_nxt;
    logic [GRANT_W-1:0]      r_grant_id, w_grant_id_nxt;
    logic [GRANT_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
    logic                    r_grant_active, w_grant_active_nxt;
    logic [c_cnt_w-1:0]      r_cnt, w_cnt_nxt;
    logic                    r_last_q, w_last_nxt;
    logic [UTXA_BYTE_W-1:0]  r_utx_data, w_data_nxt;
    logic                    r_utx_valid;
    logic                    r_timeout_evt, w_timeout_nxt;

    logic [N_REQ-1:0]        w_arb_grant;
    logic [GRANT_W-1:0]      w_arb_idx;
    logic                    w_sel_valid;
    logic [UTXA_BYTE_W-1:0]  w_sel_data;
    logic                    w_hs;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (GRANT_W)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx)
    );

    assign w_sel_valid = req_valid[r_grant_id];
    assign w_sel_data  = req_data[{r_grant_id, 3'b000} +: UTXA_BYTE_W];
    assign w_hs        = (r_state == LOCK) && w_sel_valid && !utx_busy;

    always_comb begin
        w_state_nxt        = r_state;
        w_grant_id_nxt     = r_grant_id;
        w_grant_active_nxt = r_grant_active;
        w_rr_ptr_nxt       = r_rr_ptr;
        w_cnt_nxt          = r_cnt;
        w_last_nxt         = r_last_q;
        w_data_nxt         = r_utx_data;
        w_timeout_nxt      = 1'b0;
        req_ready          = '0;
        unique case (r_state)
            IDLE: begin
                if (|w_arb_grant) begin
                    w_grant_id_nxt     = w_arb_idx;
                    w_grant_active_nxt = 1'b1;
                    w_cnt_nxt          = '0;
                    w_state_nxt        = LOCK;
                end
            end
            LOCK: begin
                if (w_hs) begin
                    req_ready[r_grant_id] = 1'b1;
                    w_data_nxt            = w_sel_data;
                    w_last_nxt            = req_last[r_grant_id];
                    w_cnt_nxt             = '0;
                    w_state_nxt           = FIRE;
                end else if (!w_sel_valid) begin
                    // Only an absent requester ages the grant; a busy uart_tx does not.
                    if (c_to_en && (r_cnt == c_cnt_last)) begin
                        w_timeout_nxt      = 1'b1;
                        w_grant_active_nxt = 1'b0;
                        w_rr_ptr_nxt       = r_grant_id;
                        w_state_nxt        = IDLE;
                    end else if (r_cnt != c_cnt_max) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            FIRE:   w_state_nxt = SETTLE;
            SETTLE: w_state_nxt = DRAIN;
            DRAIN: begin
                if (!utx_busy) begin
                    if (r_last_q) begin
                        w_grant_active_nxt = 1'b0;
                        w_rr_ptr_nxt       = r_grant_id;
                        w_state_nxt        = IDLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = LOCK;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_grant_id     <= '0;
            r_rr_ptr       <= GRANT_W'(N_REQ - 1);
            r_grant_active <= 1'b0;
            r_cnt          <= '0;
            r_last_q       <= 1'b0;
            r_utx_data     <= '0;
            r_utx_valid    <= 1'b0;
            r_timeout_evt  <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_grant_id     <= w_grant_id_nxt;
            r_rr_ptr       <= w_rr_ptr_nxt;
            r_grant_active <= w_grant_active_nxt;
            r_cnt          <= w_cnt_nxt;
            r_last_q       <= w_last_nxt;
            r_utx_data     <= w_data_nxt;
            r_utx_valid    <= (w_state_nxt == FIRE);
            r_timeout_evt  <= w_timeout_nxt;
        end
    end

    assign utx_data     = r_utx_data;
    assign utx_valid    = r_utx_valid;
    assign grant_id     = r_grant_id;
    assign grant_active = r_grant_active;
    assign timeout_evt  = r_timeout_evt;

endmodule
`default_nettype wire
